// File: rtl/spi_target_regbridge.sv
`timescale 1ns/1ps
// spi_target_regbridge: oversampled SPI mode-0 target turning frames into byte register strobes.
// Define SPI_TARGET_STATUS_EN to enable the 0x05 status read command.
module spi_target_regbridge #(
    parameter int SYNC_STAGES = 2,
    parameter int AUTOINC     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_cen,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata
);

    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [7:0] CMD_WR = 8'h02;
    localparam logic [7:0] CMD_RD = 8'h03;
`ifdef SPI_TARGET_STATUS_EN
    localparam logic [7:0] CMD_ST = 8'h05;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR_W = 3'd2,
        ADDR_R = 3'd3,
        WDATA  = 3'd4,
        RDATA  = 3'd5,
        IGNORE = 3'd6
`ifdef SPI_TARGET_STATUS_EN
        , STATUS = 3'd7
`endif
    } state_t;

    logic [NS-1:0] cen_q;
    logic [NS-1:0] sclk_q;
    logic [NS-1:0] mosi_q;
    logic          cen_s;
    logic          sclk_s;
    logic          mosi_s;
    logic          cen_d;
    logic          sclk_d;
    logic          rise_q;
    logic          fall_q;
    logic          bit_q;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [6:0]    rx_shift;
    logic [7:0]    rx_next;
    logic [7:0]    tx_shift;
    logic          re_pend;
    logic          re_q;
    logic          inc_pend;
    logic          tx_active;

`ifdef SPI_TARGET_STATUS_EN
    logic          err_sticky;
    logic [6:0]    frame_cnt;
    logic          data_seen;
    assign tx_active = (state == RDATA) || (state == STATUS);
`else
    assign tx_active = (state == RDATA);
`endif

    assign cen_s   = cen_q[NS-1];
    assign sclk_s  = sclk_q[NS-1];
    assign mosi_s  = mosi_q[NS-1];
    assign rx_next = {rx_shift, bit_q};

    // Synchronize pins and register sclk edge pulses with the matching mosi bit.
    // cen resets low so a frame only starts after cen has been seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cen_q  <= '0;
            sclk_q <= '0;
            mosi_q <= '0;
            cen_d  <= 1'b0;
            sclk_d <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            bit_q  <= 1'b0;
        end else begin
            cen_q  <= {cen_q[NS-2:0], spi_cen};
            sclk_q <= {sclk_q[NS-2:0], spi_sclk};
            mosi_q <= {mosi_q[NS-2:0], spi_mosi};
            cen_d  <= cen_s;
            sclk_d <= sclk_s;
            rise_q <= sclk_s & ~sclk_d;
            fall_q <= ~sclk_s & sclk_d;
            bit_q  <= mosi_s;
        end
    end

    // Frame FSM: command/address decode, strobes, read prefetch and miso shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            re_pend     <= 1'b0;
            re_q        <= 1'b0;
            inc_pend    <= 1'b0;
            reg_addr    <= '0;
            reg_wdata   <= '0;
            reg_we      <= 1'b0;
            reg_re      <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
`ifdef SPI_TARGET_STATUS_EN
            err_sticky  <= 1'b0;
            frame_cnt   <= '0;
            data_seen   <= 1'b0;
`endif
        end else begin
            reg_we      <= 1'b0;
            reg_re      <= re_pend;
            re_pend     <= 1'b0;
            re_q        <= reg_re;
            inc_pend    <= 1'b0;
            spi_miso_oe <= ~cen_s;
            if (inc_pend) reg_addr <= reg_addr + 8'd1;
            if (re_q) tx_shift <= reg_rdata;

            if (state == IDLE) begin
                bit_cnt  <= '0;
                spi_miso <= 1'b0;
                if (cen_d && !cen_s) state <= CMD;
            end else if (cen_s) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                spi_miso <= 1'b0;
`ifdef SPI_TARGET_STATUS_EN
                data_seen <= 1'b0;
                if (data_seen) frame_cnt <= frame_cnt + 7'd1;
                if (state == STATUS) err_sticky <= 1'b0;
                else if (bit_cnt != 3'd0) err_sticky <= 1'b1;
`endif
            end else if (rise_q) begin
                rx_shift <= rx_next[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    case (state)
                        CMD: begin
                            unique case (1'b1)
                                rx_next == CMD_WR: state <= ADDR_W;
                                rx_next == CMD_RD: state <= ADDR_R;
`ifdef SPI_TARGET_STATUS_EN
                                rx_next == CMD_ST: begin
                                    state    <= STATUS;
                                    tx_shift <= {err_sticky, frame_cnt};
                                end
`endif
                                default: begin
                                    state <= IGNORE;
`ifdef SPI_TARGET_STATUS_EN
                                    err_sticky <= 1'b1;
`endif
                                end
                            endcase
                        end
                        ADDR_W: begin
                            reg_addr <= rx_next;
                            state    <= WDATA;
                        end
                        ADDR_R: begin
                            reg_addr <= rx_next;
                            re_pend  <= 1'b1;
                            state    <= RDATA;
                        end
                        WDATA: begin
                            reg_wdata <= rx_next;
                            reg_we    <= 1'b1;
                            inc_pend  <= (AUTOINC != 0);
`ifdef SPI_TARGET_STATUS_EN
                            data_seen <= 1'b1;
`endif
                        end
                        RDATA: begin
                            if (AUTOINC != 0) reg_addr <= reg_addr + 8'd1;
                            re_pend <= 1'b1;
`ifdef SPI_TARGET_STATUS_EN
                            data_seen <= 1'b1;
`endif
                        end
`ifdef SPI_TARGET_STATUS_EN
                        STATUS: tx_shift <= {err_sticky, frame_cnt};
`endif
                        default: ;
                    endcase
                end
            end else if (fall_q) begin
                if (tx_active) begin
                    spi_miso <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end else begin
                    spi_miso <= 1'b0;
                end
            end
        end
    end

endmodule
